pipo_bank_arbiter: RTL and testbench
====================================

# pipo_bank_arbiter

Round-robin controller that shares a bank of NREG parallel-in/parallel-out registers among NREQ requesters. It accepts per-requester read/write requests, grants one requester at a time and drives the load enables and data of the external PIPO registers. It returns read data and a one-cycle acknowledge. It sits between the requesting blocks and the PIPO register bank, which it fully owns.

## Interface
- NREQ, 4, number of requesters (2..8)
- NREG, 4, number of PIPO registers in the bank (1..2**AW)
- AW, 2, register address width
- WIDTH, 4, register data width

- clk  in  1  clock, all state updates on rising edge
- clr  in  1  asynchronous active-low reset
- req  in  NREQ  request per requester, level
- wr  in  NREQ  per requester: 1 = write, 0 = read; valid while req high
- addr  in  NREQ*AW  per-requester register address, requester i at bits [i*AW +: AW]
- wdata  in  NREQ*WIDTH  per-requester write data, requester i at [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, registered
- ack  out  NREQ  one-cycle completion pulse to the granted requester, registered
- rdata  out  WIDTH  read data, registered, held until the next read completes
- busy  out  1  high whenever state is not IDLE
- reg_ld  out  NREG  one-hot load enable to PIPO register k, registered
- reg_d  out  WIDTH  data to all PIPO registers, registered
- reg_q  in  NREG*WIDTH  PIPO register outputs, register k at [k*WIDTH +: WIDTH]

## Operation
- States: IDLE, XFER, RELEASE. Reset state IDLE.
- Reset (clr low, any time, including mid-transfer): state IDLE, ptr 0, gnt 0, ack 0, rdata 0, reg_ld 0, reg_d 0, busy 0. The in-flight transfer is abandoned. No reg_ld pulse is produced after reset asserts.
- ptr is the index of the highest-priority requester. Arbitration scans ptr, ptr+1, …, ptr+NREQ-1 (mod NREQ), and the first req bit set wins.
- IDLE, any req high: at the edge, go to XFER, set gnt[winner], latch winner's wr/addr/wdata, and set ptr to winner+1 mod NREQ.
  - If the latched op is a write with addr < NREG, reg_ld[addr]=1 and reg_d=wdata. Otherwise reg_ld=0.
- IDLE, no req: stay. All outputs are held, except that ack and reg_ld are 0.
- XFER, at the edge:
  - clear reg_ld.
  - set ack[winner].
  - go to RELEASE.
  - Read with addr < NREG: rdata <= reg_q[addr].
  - Read with addr ≥ NREG: rdata <= 0.
  - Write with addr ≥ NREG: silently dropped, but still acked.
- RELEASE, at the edge: clear gnt and ack, then go to IDLE.
- Requester protocol: the requester holds req, wr, addr and wdata stable until it sees ack. It must drop req in the cycle after ack, or the request counts as a new one in IDLE.
- A req drop while granted is ignored; the transfer completes.
- reg_d holds its last value when not loading.

## Timing
- Edge 0 samples req in IDLE. Edge 1 ends XFER: the PIPO register captures reg_d, and the new value is on reg_q from RELEASE onward. Edge 2 ends RELEASE.
- Cycles: gnt is high for 2 cycles (XFER, RELEASE). ack is high for 1 cycle (RELEASE). reg_ld is high for 1 cycle (XFER).
- rdata is valid in the same cycle as ack.
- Throughput: one transfer per 3 cycles with continuous requests; the IDLE cycle between transfers is mandatory.
- Fairness: with all NREQ requesters continuously requesting, each is granted exactly once per 3*NREQ cycles.
- Read-after-write from any requester returns the new value, because the write has landed before the next IDLE.

## Test plan
- Reset: hold clr low with random req/wr/addr → gnt=0, ack=0, reg_ld=0, rdata=0, busy=0. Deassert clr; the first grant goes to the lowest-index requester.
- Single write then read: req0 writes 4'hA to reg 2 → reg_ld=4'b0100 for 1 cycle and reg_d=4'hA. req0 then reads reg 2 → rdata=4'hA with ack[0].
- Round-robin: req=4'b1111 held, each requester re-requesting after ack → grant order 0,1,2,3,0 and ack every 3 cycles.
- Priority rotation: after a grant to 1, req=4'b0011 → grant to 0 only if no higher rotated index is set; here 0 wins next, but with req=4'b1011 requester 3 wins.
- Out-of-range: NREG=3, requester writes addr 3 → no reg_ld bit set, ack given. A read of addr 3 → rdata=0.
- Mid-transfer reset: assert clr during XFER of a write → reg_ld drops immediately, ack never pulses, reg_q is unchanged, and the next arbitration starts from requester 0.

Source files
------------

// File: rtl/pipo_bank_arbiter.sv
// Round-robin arbiter that owns a bank of PIPO registers: one requester at a time
// is granted, its write is steered onto the bank's load enables or its read returned.
module pipo_bank_arbiter #(
   parameter int NREQ  = 4,
   parameter int NREG  = 4,
   parameter int AW    = 2,
   parameter int WIDTH = 4
) (
   input  logic                    clk,
   input  logic                    clr,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ-1:0]         wr,
   input  logic [NREQ*AW-1:0]      addr,
   input  logic [NREQ*WIDTH-1:0]   wdata,
   output logic [NREQ-1:0]         gnt,
   output logic [NREQ-1:0]         ack,
   output logic [WIDTH-1:0]        rdata,
   output logic                    busy,
   output logic [NREG-1:0]         reg_ld,
   output logic [WIDTH-1:0]        reg_d,
   input  logic [NREG*WIDTH-1:0]   reg_q
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {IDLE, XFER, RELEASE} state_t;

   state_t           state_q;
   logic [IW-1:0]    ptr_q;
   logic [NREQ-1:0]  gnt_q;
   logic [NREQ-1:0]  ack_q;
   logic [WIDTH-1:0] rdata_q;
   logic [WIDTH-1:0] reg_d_q;
   logic [NREG-1:0]  reg_ld_q;
   logic             wr_q;
   logic [AW-1:0]    addr_q;

   logic [AW-1:0]    addrArr  [NREQ];
   logic [WIDTH-1:0] wdataArr [NREQ];
   logic [WIDTH-1:0] regArr   [NREG];

   logic             found;
   logic [IW-1:0]    winIdx;
   logic [IW-1:0]    cand;
   logic [IW-1:0]    ptr_d;
   logic [NREQ-1:0]  gnt_d;
   logic [NREG-1:0]  reg_ld_d;
   logic [WIDTH-1:0] rdata_d;

   genvar gi;
   generate
      for (gi = 0; gi < NREQ; gi++) begin : g_req
         assign addrArr[gi]  = addr[gi*AW +: AW];
         assign wdataArr[gi] = wdata[gi*WIDTH +: WIDTH];
      end
      for (gi = 0; gi < NREG; gi++) begin : g_reg
         assign regArr[gi] = reg_q[gi*WIDTH +: WIDTH];
      end
   endgenerate

   // Rotating scan starting at ptr; the first requester found wins.
   always_comb begin
      found  = 1'b0;
      winIdx = '0;
      cand   = '0;
      for (int i = 0; i < NREQ; i++) begin
         cand = IW'((int'(ptr_q) + i) % NREQ);
         if (!found && req[cand]) begin
            found  = 1'b1;
            winIdx = cand;
         end
      end
   end

   always_comb begin
      ptr_d         = (winIdx == IW'(NREQ - 1)) ? '0 : winIdx + IW'(1);
      gnt_d         = '0;
      gnt_d[winIdx] = 1'b1;
      reg_ld_d      = '0;
      for (int k = 0; k < NREG; k++) begin
         if (wr[winIdx] && (addrArr[winIdx] == AW'(k))) begin
            reg_ld_d[k] = 1'b1;
         end
      end
   end

   // An address with no matching register reads back as zero.
   always_comb begin
      rdata_d = '0;
      for (int k = 0; k < NREG; k++) begin
         if (addr_q == AW'(k)) begin
            rdata_d = regArr[k];
         end
      end
   end

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state_q  <= IDLE;
         ptr_q    <= '0;
         gnt_q    <= '0;
         ack_q    <= '0;
         rdata_q  <= '0;
         reg_d_q  <= '0;
         reg_ld_q <= '0;
         wr_q     <= 1'b0;
         addr_q   <= '0;
      end else begin
         ack_q    <= '0;
         reg_ld_q <= '0;
         case (state_q)
            IDLE: begin
               if (found) begin
                  state_q  <= XFER;
                  gnt_q    <= gnt_d;
                  ptr_q    <= ptr_d;
                  wr_q     <= wr[winIdx];
                  addr_q   <= addrArr[winIdx];
                  reg_ld_q <= reg_ld_d;
                  if (|reg_ld_d) begin
                     reg_d_q <= wdataArr[winIdx];
                  end
               end
            end
            XFER: begin
               state_q <= RELEASE;
               ack_q   <= gnt_q;
               if (!wr_q) begin
                  rdata_q <= rdata_d;
               end
            end
            RELEASE: begin
               state_q <= IDLE;
               gnt_q   <= '0;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt    = gnt_q;
   assign ack    = ack_q;
   assign rdata  = rdata_q;
   assign reg_ld = reg_ld_q;
   assign reg_d  = reg_d_q;
   assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_pipo_bank_arbiter.sv
// Bench for pipo_bank_arbiter: directed scenarios plus random traffic checked
// against a transaction-level model of arbitration and the register bank.
module tb_pipo_bank_arbiter;

   localparam int NREQ  = 4;
   localparam int NREG  = 3;
   localparam int AW    = 2;
   localparam int WIDTH = 4;

   logic                  clk = 1'b0;
   logic                  clr;
   logic [NREQ-1:0]       req;
   logic [NREQ-1:0]       wr;
   logic [NREQ*AW-1:0]    addr;
   logic [NREQ*WIDTH-1:0] wdata;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [WIDTH-1:0]      rdata;
   logic                  busy;
   logic [NREG-1:0]       reg_ld;
   logic [WIDTH-1:0]      reg_d;
   logic [NREG*WIDTH-1:0] reg_q;

   logic [WIDTH-1:0]      bank [NREG];

   int checks = 0;
   int errors = 0;

   logic [WIDTH-1:0]      mem [NREG];
   int                    mPtr;
   logic [WIDTH-1:0]      mRegD;
   logic [WIDTH-1:0]      mRdata;

   pipo_bank_arbiter #(
      .NREQ(NREQ), .NREG(NREG), .AW(AW), .WIDTH(WIDTH)
   ) dut (
      .clk(clk), .clr(clr), .req(req), .wr(wr), .addr(addr), .wdata(wdata),
      .gnt(gnt), .ack(ack), .rdata(rdata), .busy(busy),
      .reg_ld(reg_ld), .reg_d(reg_d), .reg_q(reg_q)
   );

   always #5 clk = ~clk;

   // The external PIPO bank: each register loads reg_d when its enable is high.
   always @(posedge clk) begin
      for (int k = 0; k < NREG; k++) begin
         if (reg_ld[k]) bank[k] <= reg_d;
      end
   end

   always_comb begin
      reg_q = '0;
      for (int k = 0; k < NREG; k++) reg_q[k*WIDTH +: WIDTH] = bank[k];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clearInputs();
      req = '0; wr = '0; addr = '0; wdata = '0;
   endtask

   task automatic setReq(input int i, input logic w, input int a, input logic [WIDTH-1:0] d);
      req[i] = 1'b1;
      wr[i]  = w;
      addr[i*AW +: AW]       = AW'(a);
      wdata[i*WIDTH +: WIDTH] = d;
   endtask

   task automatic doReset();
      clr = 1'b0;
      clearInputs();
      tick();
      tick();
      clr = 1'b1;
      mPtr = 0; mRegD = '0; mRdata = '0;
   endtask

   task automatic test_reset();
      logic [NREQ-1:0] r;
      int low;
      clr = 1'b0;
      for (int c = 0; c < 4; c++) begin
         req = NREQ'($urandom); wr = NREQ'($urandom);
         addr = (NREQ*AW)'($urandom); wdata = (NREQ*WIDTH)'($urandom);
         tick();
         checks++;
         if (gnt !== '0 || ack !== '0 || reg_ld !== '0 || rdata !== '0 || busy !== 1'b0 || reg_d !== '0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: gnt=%b ack=%b reg_ld=%b rdata=%h busy=%b reg_d=%h expected all zero",
                     gnt, ack, reg_ld, rdata, busy, reg_d);
         end
      end
      r = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      low = -1;
      for (int i = NREQ - 1; i >= 0; i--) if (r[i]) low = i;
      req = r;
      clr = 1'b1;
      tick();
      checks++;
      if (gnt !== NREQ'(1 << low)) begin
         errors++;
         $display("[TB] FAIL reset_first_grant: got %b expected %b", gnt, NREQ'(1 << low));
      end
      tick();
      clearInputs();
      tick();
   endtask

   task automatic test_write_read();
      doReset();
      setReq(0, 1'b1, 2, 4'hA);
      tick();
      checks++;
      if (reg_ld !== 3'b100 || reg_d !== 4'hA || gnt !== 4'b0001 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL write_xfer: reg_ld=%b reg_d=%h gnt=%b busy=%b expected 100 a 0001 1",
                  reg_ld, reg_d, gnt, busy);
      end
      tick();
      checks++;
      if (reg_ld !== '0 || ack !== 4'b0001 || gnt !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL write_release: reg_ld=%b ack=%b gnt=%b expected 000 0001 0001", reg_ld, ack, gnt);
      end
      clearInputs();
      tick();
      checks++;
      if (gnt !== '0 || ack !== '0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL write_idle: gnt=%b ack=%b busy=%b expected 0000 0000 0", gnt, ack, busy);
      end
      setReq(0, 1'b0, 2, 4'h0);
      tick();
      tick();
      checks++;
      if (ack !== 4'b0001 || rdata !== 4'hA) begin
         errors++;
         $display("[TB] FAIL read_back: ack=%b rdata=%h expected 0001 a", ack, rdata);
      end
      clearInputs();
      tick();
   endtask

   task automatic test_round_robin();
      doReset();
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         tick();
         checks++;
         if (gnt !== NREQ'(1 << (t % NREQ))) begin
            errors++;
            $display("[TB] FAIL rr_grant%0d: got %b expected %b", t, gnt, NREQ'(1 << (t % NREQ)));
         end
         tick();
         checks++;
         if (ack !== NREQ'(1 << (t % NREQ))) begin
            errors++;
            $display("[TB] FAIL rr_ack%0d: got %b expected %b", t, ack, NREQ'(1 << (t % NREQ)));
         end
         tick();
         checks++;
         if (ack !== '0 || gnt !== '0) begin
            errors++;
            $display("[TB] FAIL rr_gap%0d: ack=%b gnt=%b expected 0000 0000", t, ack, gnt);
         end
      end
      clearInputs();
      tick();
   endtask

   task automatic test_priority();
      logic [NREQ-1:0] reqs [4];
      int              exp  [4];
      reqs = '{4'b0010, 4'b0011, 4'b0010, 4'b1011};
      exp  = '{1, 0, 1, 3};
      doReset();
      for (int t = 0; t < 4; t++) begin
         req = reqs[t];
         tick();
         checks++;
         if (gnt !== NREQ'(1 << exp[t])) begin
            errors++;
            $display("[TB] FAIL prio_grant%0d: got %b expected %b", t, gnt, NREQ'(1 << exp[t]));
         end
         tick();
         req = '0;
         tick();
      end
   endtask

   task automatic test_out_of_range();
      logic [WIDTH-1:0] snap [NREG];
      doReset();
      snap = bank;
      setReq(2, 1'b1, 3, 4'h5);
      tick();
      checks++;
      if (reg_ld !== '0 || gnt !== 4'b0100 || reg_d !== 4'h0) begin
         errors++;
         $display("[TB] FAIL oor_write: reg_ld=%b gnt=%b reg_d=%h expected 000 0100 0", reg_ld, gnt, reg_d);
      end
      tick();
      checks++;
      if (ack !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL oor_write_ack: got %b expected 0100", ack);
      end
      clearInputs();
      tick();
      checks++;
      if (bank !== snap) begin
         errors++;
         $display("[TB] FAIL oor_bank: bank contents changed by out-of-range write");
      end
      setReq(2, 1'b1, 1, 4'hC);
      tick(); tick();
      clearInputs();
      tick();
      setReq(2, 1'b0, 1, 4'h0);
      tick(); tick();
      checks++;
      if (rdata !== 4'hC) begin
         errors++;
         $display("[TB] FAIL oor_pre_read: rdata=%h expected c", rdata);
      end
      clearInputs();
      tick();
      setReq(2, 1'b0, 3, 4'h0);
      tick(); tick();
      checks++;
      if (rdata !== 4'h0 || ack !== 4'b0100) begin
         errors++;
         $display("[TB] FAIL oor_read: rdata=%h ack=%b expected 0 0100", rdata, ack);
      end
      clearInputs();
      tick();
   endtask

   task automatic test_mid_reset();
      doReset();
      setReq(0, 1'b1, 0, 4'h3);
      tick(); tick();
      clearInputs();
      tick();
      setReq(1, 1'b1, 0, 4'hE);
      tick();
      checks++;
      if (reg_ld !== 3'b001) begin
         errors++;
         $display("[TB] FAIL midrst_pre: reg_ld=%b expected 001", reg_ld);
      end
      #1;
      clr = 1'b0;
      #1;
      checks++;
      if (reg_ld !== '0 || gnt !== '0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL midrst_async: reg_ld=%b gnt=%b busy=%b expected 000 0000 0", reg_ld, gnt, busy);
      end
      tick();
      checks++;
      if (ack !== '0 || bank[0] !== 4'h3) begin
         errors++;
         $display("[TB] FAIL midrst_abandon: ack=%b bank0=%h expected 0000 3", ack, bank[0]);
      end
      clr = 1'b1;
      clearInputs();
      req = 4'b1111;
      tick();
      checks++;
      if (gnt !== 4'b0001) begin
         errors++;
         $display("[TB] FAIL midrst_restart: gnt=%b expected 0001", gnt);
      end
      tick();
      clearInputs();
      tick();
   endtask

   task automatic test_random();
      logic [NREQ-1:0]       r, wrv;
      logic [NREQ*AW-1:0]    addrv;
      logic [NREQ*WIDTH-1:0] wdv;
      logic [NREQ-1:0]       expG;
      logic [NREG-1:0]       expLd;
      logic [WIDTH-1:0]      d;
      int                    w, a, idx;
      doReset();
      for (int n = 0; n < 80; n++) begin
         r = NREQ'($urandom); wrv = NREQ'($urandom);
         addrv = (NREQ*AW)'($urandom); wdv = (NREQ*WIDTH)'($urandom);
         if (n < NREG) begin
            r = NREQ'(1 << (n % NREQ));
            wrv = '1;
            for (int i = 0; i < NREQ; i++) addrv[i*AW +: AW] = AW'(n);
         end
         req = r; wr = wrv; addr = addrv; wdata = wdv;
         if (r == '0) begin
            tick();
            checks++;
            if (gnt !== '0 || ack !== '0 || reg_ld !== '0 || busy !== 1'b0 || rdata !== mRdata || reg_d !== mRegD) begin
               errors++;
               $display("[TB] FAIL rand_idle%0d: gnt=%b ack=%b reg_ld=%b busy=%b rdata=%h reg_d=%h expected 0 0 0 0 %h %h",
                        n, gnt, ack, reg_ld, busy, rdata, reg_d, mRdata, mRegD);
            end
            continue;
         end
         w = -1;
         for (int i = 0; i < NREQ; i++) begin
            idx = (mPtr + i) % NREQ;
            if (w < 0 && r[idx]) w = idx;
         end
         mPtr = (w + 1) % NREQ;
         a = int'(addrv[w*AW +: AW]);
         d = wdv[w*WIDTH +: WIDTH];
         expG = '0; expG[w] = 1'b1;
         expLd = '0;
         if (wrv[w] && a < NREG) begin
            expLd[a] = 1'b1;
            mRegD = d;
         end
         if (!wrv[w]) mRdata = (a < NREG) ? mem[a] : '0;
         tick();
         checks++;
         if (gnt !== expG || reg_ld !== expLd || reg_d !== mRegD || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rand_xfer%0d: gnt=%b reg_ld=%b reg_d=%h busy=%b expected %b %b %h 1",
                     n, gnt, reg_ld, reg_d, busy, expG, expLd, mRegD);
         end
         req = NREQ'($urandom);
         tick();
         checks++;
         if (ack !== expG || gnt !== expG || rdata !== mRdata || reg_ld !== '0) begin
            errors++;
            $display("[TB] FAIL rand_ack%0d: ack=%b gnt=%b rdata=%h reg_ld=%b expected %b %b %h 000",
                     n, ack, gnt, rdata, reg_ld, expG, expG, mRdata);
         end
         if (wrv[w] && a < NREG) mem[a] = d;
         req = '0;
         tick();
         checks++;
         if (gnt !== '0 || ack !== '0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rand_release%0d: gnt=%b ack=%b busy=%b expected 0000 0000 0", n, gnt, ack, busy);
         end
      end
      clearInputs();
      tick();
   endtask

   initial begin
      clr = 1'b0;
      clearInputs();
      #2;
      test_reset();
      test_write_read();
      test_round_robin();
      test_priority();
      test_out_of_range();
      test_mid_reset();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
